// File: rtl/timer_pkg.sv
// Shared constants for the timer register bank: register map, CTRL field layout,
// mode encodings and the clock-source-off value.
package timer_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_TOP      = 3'd1;
  localparam logic [2:0] ADDR_CNTA     = 3'd2;
  localparam logic [2:0] ADDR_CNTB     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd5;

  localparam int unsigned CTRL_SRC_LSB  = 0;
  localparam int unsigned CTRL_MODE_LSB = 2;
  localparam int unsigned CTRL_FIELD_W  = 2;

  localparam int unsigned STAT_IRQ_BIT  = 0;
  localparam int unsigned STAT_PEND_BIT = 1;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FAST   = 2'b01,
    MODE_PHASE  = 2'b10
  } tmr_mode_e;

  localparam logic [1:0] SRC_OFF = 2'b00;

  // True for the three double-buffered period/compare registers.
  function automatic logic is_buffered(input logic [2:0] a);
    return (a == ADDR_TOP) || (a == ADDR_CNTA) || (a == ADDR_CNTB);
  endfunction

endpackage

// File: rtl/timer_irq_edge.sv
// Rising-edge detector for the generator's timer_interrupt; one evt per edge
// regardless of pulse width.
module timer_irq_edge
  import timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic timer_interrupt,
  output logic evt
);

  logic tmr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q <= 1'b0;
    end else begin
      tmr_q <= timer_interrupt;
    end
  end

  // tmr_q clears in reset, so a level held across release is seen as an edge.
  assign evt = timer_interrupt & ~tmr_q;

endmodule

// File: rtl/timer_reg_bank.sv
// Register bank and interrupt front-end for Timer_PWM_Generator.
// Build option: define TIMER_SHADOW_EN for period-boundary shadowing of TOP/CNTA/CNTB.
module timer_reg_bank
  import timer_pkg::*;
#(
  parameter logic [31:0] TOP_RST = 32'hFFFF_FFFF,
  parameter logic [31:0] CNT_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        timer_interrupt,
  output logic [1:0]  TMR_SRC,
  output logic [1:0]  TMR_MODE,
  output logic [31:0] TIMER_TOP,
  output logic [31:0] PWM_CNTA,
  output logic [31:0] PWM_CNTB,
  output logic        irq
);

  logic        evt;
  logic        wr_ctrl;
  logic        wr_top;
  logic        wr_cnta;
  logic        wr_cntb;
  logic        wr_irq_en;
  logic        w1c_stat;
  logic        irq_en;
  logic        irq_stat;
  logic        irq_stat_nxt;
  logic [31:0] top_rd;
  logic [31:0] cnta_rd;
  logic [31:0] cntb_rd;
  logic        pend_rd;
  logic [31:0] rd_mux;

  timer_irq_edge u_irq_edge (
    .clk             (clk),
    .reset           (reset),
    .timer_interrupt (timer_interrupt),
    .evt             (evt)
  );

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_top    = wr_en && (addr == ADDR_TOP);
  assign wr_cnta   = wr_en && (addr == ADDR_CNTA);
  assign wr_cntb   = wr_en && (addr == ADDR_CNTB);
  assign wr_irq_en = wr_en && (addr == ADDR_IRQ_EN);
  assign w1c_stat  = wr_en && (addr == ADDR_IRQ_STAT) && wdata[STAT_IRQ_BIT];

  always_comb begin
    irq_stat_nxt = irq_stat;
    if (w1c_stat) irq_stat_nxt = 1'b0;
    if (evt)      irq_stat_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      TMR_SRC  <= SRC_OFF;
      TMR_MODE <= MODE_NORMAL;
      irq_en   <= 1'b0;
      irq_stat <= 1'b0;
      irq      <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      if (wr_ctrl) begin
        TMR_SRC  <= wdata[CTRL_SRC_LSB +: CTRL_FIELD_W];
        TMR_MODE <= wdata[CTRL_MODE_LSB +: CTRL_FIELD_W];
      end
      if (wr_irq_en) irq_en <= wdata[0];
      irq_stat <= irq_stat_nxt;
      irq      <= irq_stat & irq_en;
      rvalid   <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

`ifdef TIMER_SHADOW_EN
  logic [31:0] top_sh;
  logic [31:0] cnta_sh;
  logic [31:0] cntb_sh;
  logic        upd_pend;
  logic        xfer;
  logic        wr_buf;

  assign wr_buf = wr_en && is_buffered(addr);
  assign xfer   = upd_pend && ((TMR_SRC == SRC_OFF) || evt);

  // Transfer reads the shadows before this edge's write lands, so a colliding
  // write leaves upd_pend set for the next boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      top_sh    <= TOP_RST;
      cnta_sh   <= CNT_RST;
      cntb_sh   <= CNT_RST;
      TIMER_TOP <= TOP_RST;
      PWM_CNTA  <= CNT_RST;
      PWM_CNTB  <= CNT_RST;
      upd_pend  <= 1'b0;
    end else begin
      if (wr_top)  top_sh  <= wdata;
      if (wr_cnta) cnta_sh <= wdata;
      if (wr_cntb) cntb_sh <= wdata;
      if (xfer) begin
        TIMER_TOP <= top_sh;
        PWM_CNTA  <= cnta_sh;
        PWM_CNTB  <= cntb_sh;
      end
      if (wr_buf) begin
        upd_pend <= 1'b1;
      end else if (xfer) begin
        upd_pend <= 1'b0;
      end
    end
  end

  assign top_rd  = top_sh;
  assign cnta_rd = cnta_sh;
  assign cntb_rd = cntb_sh;
  assign pend_rd = upd_pend;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      TIMER_TOP <= TOP_RST;
      PWM_CNTA  <= CNT_RST;
      PWM_CNTB  <= CNT_RST;
    end else begin
      if (wr_top)  TIMER_TOP <= wdata;
      if (wr_cnta) PWM_CNTA  <= wdata;
      if (wr_cntb) PWM_CNTB  <= wdata;
    end
  end

  assign top_rd  = TIMER_TOP;
  assign cnta_rd = PWM_CNTA;
  assign cntb_rd = PWM_CNTB;
  assign pend_rd = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_SRC_LSB +: CTRL_FIELD_W]  = TMR_SRC;
        rd_mux[CTRL_MODE_LSB +: CTRL_FIELD_W] = TMR_MODE;
      end
      ADDR_TOP:    rd_mux = top_rd;
      ADDR_CNTA:   rd_mux = cnta_rd;
      ADDR_CNTB:   rd_mux = cntb_rd;
      ADDR_IRQ_EN: rd_mux[0] = irq_en;
      ADDR_IRQ_STAT: begin
        rd_mux[STAT_IRQ_BIT]  = irq_stat;
        rd_mux[STAT_PEND_BIT] = pend_rd;
      end
      default:     rd_mux = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_reg_bank.sv
// Directed self-checking bench for timer_reg_bank; covers both TIMER_SHADOW_EN builds.
module tb_timer_reg_bank;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        timer_interrupt;
  logic [1:0]  TMR_SRC;
  logic [1:0]  TMR_MODE;
  logic [31:0] TIMER_TOP;
  logic [31:0] PWM_CNTA;
  logic [31:0] PWM_CNTB;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  timer_reg_bank #(
    .TOP_RST (32'hFFFF_FFFF),
    .CNT_RST (32'd0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .wdata           (wdata),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .timer_interrupt (timer_interrupt),
    .TMR_SRC         (TMR_SRC),
    .TMR_MODE        (TMR_MODE),
    .TIMER_TOP       (TIMER_TOP),
    .PWM_CNTA        (PWM_CNTA),
    .PWM_CNTB        (PWM_CNTB),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    logic [31:0] exp_rd [8];
    exp_rd = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if ({TMR_SRC, TMR_MODE, irq, rvalid} !== 6'b0 || rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: src=%0d mode=%0d irq=%0b rvalid=%0b rdata=%h expected all 0",
               TMR_SRC, TMR_MODE, irq, rvalid, rdata);
    end
    vectors++;
    if (TIMER_TOP !== 32'hFFFF_FFFF || PWM_CNTA !== 32'd0 || PWM_CNTB !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_active: top=%h a=%h b=%h expected ffffffff/0/0", TIMER_TOP, PWM_CNTA, PWM_CNTB);
    end
    reset = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      do_read(3'(i), d, v);
      vectors++;
      if (d !== exp_rd[i] || v !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got %h rvalid=%0b expected %h rvalid=1", i, d, v, exp_rd[i]);
      end
    end
  endtask

`ifdef TIMER_SHADOW_EN
  task automatic test_disabled_write();
    logic [31:0] d;
    logic v;
    do_write(ADDR_TOP, 32'd100);
    vectors++;
    if (TIMER_TOP !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL off_write_early: TIMER_TOP=%h expected ffffffff", TIMER_TOP);
    end
    tick();
    vectors++;
    if (TIMER_TOP !== 32'd100) begin
      miscompares++;
      $display("FAIL off_write_xfer: TIMER_TOP=%0d expected 100", TIMER_TOP);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL off_write_pend: IRQ_STAT=%h expected 0", d);
    end
  endtask

  task automatic test_running_shadow();
    logic [31:0] d;
    logic v;
    do_write(ADDR_CTRL, 32'h1);
    do_write(ADDR_CNTA, 32'd50);
    do_write(ADDR_CNTB, 32'd25);
    tick(); tick(); tick();
    vectors++;
    if (PWM_CNTA !== 32'd0 || PWM_CNTB !== 32'd0 || TMR_SRC !== 2'b01) begin
      miscompares++;
      $display("FAIL shadow_hold: a=%0d b=%0d src=%0d expected 0/0/1", PWM_CNTA, PWM_CNTB, TMR_SRC);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL shadow_pend: IRQ_STAT=%h expected 2", d);
    end
    timer_interrupt = 1'b1;
    tick();
    timer_interrupt = 1'b0;
    vectors++;
    if (PWM_CNTA !== 32'd50 || PWM_CNTB !== 32'd25 || TIMER_TOP !== 32'd100) begin
      miscompares++;
      $display("FAIL shadow_xfer: a=%0d b=%0d top=%0d expected 50/25/100", PWM_CNTA, PWM_CNTB, TIMER_TOP);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL shadow_after: IRQ_STAT=%h expected 1", d);
    end
    do_write(ADDR_IRQ_STAT, 32'h1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v;
    do_write(ADDR_CNTA, 32'd50);
    do_write(ADDR_CNTB, 32'd30);
    addr = ADDR_CNTA; wdata = 32'd60; wr_en = 1'b1; timer_interrupt = 1'b1;
    tick();
    wr_en = 1'b0; timer_interrupt = 1'b0;
    vectors++;
    if (PWM_CNTA !== 32'd50 || PWM_CNTB !== 32'd30) begin
      miscompares++;
      $display("FAIL collide_xfer: a=%0d b=%0d expected 50/30", PWM_CNTA, PWM_CNTB);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h3) begin
      miscompares++;
      $display("FAIL collide_pend: IRQ_STAT=%h expected 3", d);
    end
    do_read(ADDR_CNTA, d, v);
    vectors++;
    if (d !== 32'd60) begin
      miscompares++;
      $display("FAIL collide_shadow: CNTA=%0d expected 60", d);
    end
    timer_interrupt = 1'b1;
    tick();
    timer_interrupt = 1'b0;
    vectors++;
    if (PWM_CNTA !== 32'd60 || PWM_CNTB !== 32'd30) begin
      miscompares++;
      $display("FAIL collide_next: a=%0d b=%0d expected 60/30", PWM_CNTA, PWM_CNTB);
    end
    do_write(ADDR_IRQ_STAT, 32'h1);
  endtask

  task automatic test_src_off_switch();
    logic [31:0] d;
    logic v;
    do_write(ADDR_TOP, 32'd200);
    tick();
    do_write(ADDR_CTRL, 32'h0);
    vectors++;
    if (TIMER_TOP !== 32'd100 || TMR_SRC !== 2'b00) begin
      miscompares++;
      $display("FAIL srcoff_hold: top=%0d src=%0d expected 100/0", TIMER_TOP, TMR_SRC);
    end
    tick();
    vectors++;
    if (TIMER_TOP !== 32'd200) begin
      miscompares++;
      $display("FAIL srcoff_xfer: top=%0d expected 200", TIMER_TOP);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL srcoff_pend: IRQ_STAT=%h expected 0", d);
    end
    do_write(ADDR_CTRL, 32'h1);
  endtask
`else
  task automatic test_direct();
    logic [31:0] d;
    logic v;
    do_write(ADDR_TOP, 32'd100);
    vectors++;
    if (TIMER_TOP !== 32'd100) begin
      miscompares++;
      $display("FAIL direct_top: TIMER_TOP=%0d expected 100", TIMER_TOP);
    end
    do_write(ADDR_CNTA, 32'd50);
    do_write(ADDR_CNTB, 32'd25);
    vectors++;
    if (PWM_CNTA !== 32'd50 || PWM_CNTB !== 32'd25) begin
      miscompares++;
      $display("FAIL direct_cnt: a=%0d b=%0d expected 50/25", PWM_CNTA, PWM_CNTB);
    end
    do_read(ADDR_CNTA, d, v);
    vectors++;
    if (d !== 32'd50) begin
      miscompares++;
      $display("FAIL direct_read: CNTA=%0d expected 50", d);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL direct_stat: IRQ_STAT=%h expected 0", d);
    end
    do_write(ADDR_CTRL, 32'h1);
  endtask
`endif

  task automatic test_interrupt();
    logic [31:0] d;
    logic v;
    do_write(ADDR_IRQ_EN, 32'h1);
    tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_idle: irq=%0b expected 0", irq);
    end
    timer_interrupt = 1'b1;
    tick(); tick();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: irq=%0b expected 1", irq);
    end
    do_write(ADDR_IRQ_STAT, 32'h1);
    timer_interrupt = 1'b0;
    tick(); tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_single: irq=%0b expected 0", irq);
    end
    addr = ADDR_IRQ_STAT; wdata = 32'h1; wr_en = 1'b1; timer_interrupt = 1'b1;
    tick();
    wr_en = 1'b0; timer_interrupt = 1'b0;
    tick(); tick();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set_wins: irq=%0b expected 1", irq);
    end
    do_write(ADDR_IRQ_EN, 32'h0);
    tick(); tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_mask: irq=%0b expected 0", irq);
    end
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL irq_stat_masked: IRQ_STAT=%h expected 1", d);
    end
    do_write(ADDR_IRQ_EN, 32'h1);
    tick(); tick();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_unmask: irq=%0b expected 1", irq);
    end
    do_write(ADDR_IRQ_STAT, 32'h1);
    tick(); tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: irq=%0b expected 0", irq);
    end
  endtask

  task automatic test_mode_change();
    logic [31:0] d;
    logic v;
    do_write(ADDR_CTRL, 32'h5);
    vectors++;
    if (TMR_MODE !== MODE_FAST || TMR_SRC !== 2'b01) begin
      miscompares++;
      $display("FAIL mode_fast: mode=%0d src=%0d expected 1/1", TMR_MODE, TMR_SRC);
    end
    addr = ADDR_CTRL; rd_en = 1'b1;
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rvalid_pre: rvalid=%0b expected 0", rvalid);
    end
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL rvalid_pulse: rvalid=%0b rdata=%h expected 1/5", rvalid, rdata);
    end
    tick();
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL rvalid_drop: rvalid=%0b rdata=%h expected 0/5 held", rvalid, rdata);
    end
    do_write(ADDR_CTRL, 32'h9);
    vectors++;
    if (TMR_MODE !== MODE_PHASE || TMR_SRC !== 2'b01) begin
      miscompares++;
      $display("FAIL mode_phase: mode=%0d src=%0d expected 2/1", TMR_MODE, TMR_SRC);
    end
    addr = ADDR_CTRL; wdata = 32'hFFFF_FFF1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++;
    if (rdata !== 32'h9 || rvalid !== 1'b1 || TMR_MODE !== MODE_NORMAL) begin
      miscompares++;
      $display("FAIL rw_same: rdata=%h rvalid=%0b mode=%0d expected 9/1/0", rdata, rvalid, TMR_MODE);
    end
    do_read(ADDR_CTRL, d, v);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL ctrl_mask: CTRL=%h expected 1", d);
    end
    do_write(3'd6, 32'hDEAD_BEEF);
    do_read(3'd6, d, v);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reserved: addr6=%h expected 0", d);
    end
  endtask

  task automatic test_reset_edge();
    logic [31:0] d;
    logic v;
    do_write(ADDR_TOP, 32'd300);
`ifdef TIMER_SHADOW_EN
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL rst_pend_before: IRQ_STAT=%h expected 2", d);
    end
`endif
    timer_interrupt = 1'b1;
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if (TIMER_TOP !== 32'hFFFF_FFFF || irq !== 1'b0 || TMR_SRC !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid: top=%h irq=%0b src=%0d expected ffffffff/0/0", TIMER_TOP, irq, TMR_SRC);
    end
    reset = 1'b1;
    tick();
    timer_interrupt = 1'b0;
    do_read(ADDR_IRQ_STAT, d, v);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL rst_edge_evt: IRQ_STAT=%h expected 1", d);
    end
    do_read(ADDR_TOP, d, v);
    vectors++;
    if (d !== 32'hFFFF_FFFF || TIMER_TOP !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL rst_discard: TOP=%h active=%h expected ffffffff", d, TIMER_TOP);
    end
  endtask

  initial begin
    reset = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; timer_interrupt = 1'b0;
    #1;
    test_reset();
`ifdef TIMER_SHADOW_EN
    test_disabled_write();
    test_running_shadow();
    test_back_to_back();
    test_src_off_switch();
`else
    test_direct();
`endif
    test_interrupt();
    test_mode_change();
    test_reset_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_reg_bank.md
# timer_reg_bank

- Register bank and interrupt front-end sitting directly upstream of `Timer_PWM_Generator`.
- A simple single-cycle bus writes and reads the timer configuration.
- The block drives `TMR_SRC`, `TMR_MODE`, `TIMER_TOP`, `PWM_CNTA` and `PWM_CNTB` into the generator, with glitch-free shadow update at period boundaries.
- It consumes the generator's `timer_interrupt` and turns it into a latched, maskable CPU interrupt.

## Interface
Parameters:
- `TOP_RST`, 32'hFFFF_FFFF, reset value of `TIMER_TOP` (shadow and active).
- `CNT_RST`, 32'd0, reset value of `PWM_CNTA`/`PWM_CNTB` (shadow and active).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  3  word address of the register.
- `wr_en`  in  1  write strobe, one transfer per cycle.
- `rd_en`  in  1  read strobe.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, valid when `rvalid` is high.
- `rvalid`  out  1  one-cycle pulse, one cycle after `rd_en`.
- `timer_interrupt`  in  1  period/overflow pulse from the generator.
- `TMR_SRC`  out  2  active clock-source select.
- `TMR_MODE`  out  2  active mode (00 normal, 01 fast PWM, 10 phase-correct).
- `TIMER_TOP`  out  32  active period.
- `PWM_CNTA`  out  32  active compare A.
- `PWM_CNTB`  out  32  active compare B.
- `irq`  out  1  `irq_stat & irq_en`.

## Operation
Register map (word address):
- 0 CTRL: [1:0] `TMR_SRC`, [3:2] `TMR_MODE`. Writes take effect directly (unbuffered). Other bits read 0.
- 1 TOP, 2 CNTA, 3 CNTB: buffered. Writes land in the shadow register. Reads return the shadow value.
- 4 IRQ_EN: bit 0.
- 5 IRQ_STAT: bit 0 `irq_stat`, write-1-to-clear. Bit 1 `upd_pend`, read-only.
- 6, 7: reserved. Read 0, writes ignored.

Event detection:
- `evt = timer_interrupt & ~tmr_q`, where `tmr_q` is the registered `timer_interrupt`.
- Each rising edge is one event, regardless of pulse width.

Shadow transfer (copy all three shadows to active outputs):
- If `TMR_SRC` (active) is not 00, a write to address 1–3 sets `upd_pend`. Transfer happens on the first `evt` while `upd_pend` is set, and clears `upd_pend`.
- If `TMR_SRC` is 00, every cycle with `upd_pend` set transfers. Buffered writes therefore reach the outputs 2 cycles after the write strobe.

Interrupt:
- `evt` sets `irq_stat`.
- W1C of bit 0 clears it.

Boundary rules:
- A buffered write in the same cycle as a transfer: the transfer uses the pre-write shadow contents, and `upd_pend` stays set for the new value.
- `evt` and W1C in the same cycle: set wins, so `irq_stat` = 1.
- Write and read of the same address in the same cycle: `rdata` returns the pre-write value.
- `wr_en` and `rd_en` together are legal.
- Writing CTRL with `TMR_SRC`=00 while `upd_pend` is set: the transfer happens on the following cycle.
- Reset while `upd_pend` is set discards the pending values.

## Timing
- Reset values (all outputs and state):
  - `TMR_SRC`=0, `TMR_MODE`=0
  - `TIMER_TOP`=`TOP_RST`, `PWM_CNTA`=`PWM_CNTB`=`CNT_RST` (active and shadow)
  - `irq_en`=0, `irq_stat`=0, `upd_pend`=0, `tmr_q`=0
  - `irq`=0, `rdata`=0, `rvalid`=0
- Read latency is 1 cycle. `rdata` holds its value until the next read.
- CTRL write: the outputs change on the clock edge that samples `wr_en`.
- Shadow transfer: active outputs change on the clock edge that samples `evt`. All three change together, never partially.
- `irq` is registered. It rises 1 cycle after the `timer_interrupt` edge is sampled.
- `timer_interrupt` held high across reset release counts as an event on the first cycle out of reset.

## Configuration
- Macro `TIMER_SHADOW_EN`.
- Defined: the buffered behaviour above.
- Undefined:
  - Shadow registers and `upd_pend` are removed.
  - Writes to addresses 1–3 update the active outputs on the write edge.
  - IRQ_STAT bit 1 reads 0.
  - Reads of addresses 1–3 return the active value.

## Structure
- Package `timer_pkg`:
  - Address constants `ADDR_CTRL` … `ADDR_IRQ_STAT`.
  - CTRL field positions.
  - Mode encodings `MODE_NORMAL`/`MODE_FAST`/`MODE_PHASE`.
  - `SRC_OFF` constant.
- One sub-module, `timer_irq_edge`: registers `timer_interrupt` and emits `evt`. Synchronous active-low reset.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then read all addresses. Expect CTRL=0, TOP=FFFF_FFFF, CNTA=CNTB=0, IRQ_EN=0, IRQ_STAT=0, `irq`=0.
- Disabled write: with `TMR_SRC`=00, write TOP=100. Expect `TIMER_TOP`=100 two cycles after the strobe, and `upd_pend` returns to 0.
- Running shadow: set CTRL=0x1 (SRC 01, normal). Write CNTA=50, CNTB=25. Expect `PWM_CNTA`/`PWM_CNTB` unchanged and IRQ_STAT bit 1=1 until the next `timer_interrupt` edge, then both update on the same edge and bit 1 reads 0.
- Simultaneous write and event: write CNTA=60 in the `evt` cycle with CNTA shadow at 50. Expect `PWM_CNTA`=50 and `upd_pend`=1, then 60 after the following event.
- Interrupt: set IRQ_EN=1 and pulse `timer_interrupt` for 3 cycles. Expect `irq`=1 a single time; a W1C in the same cycle as a new edge leaves `irq`=1; a later W1C gives `irq`=0.
- Mode change: write CTRL=0x5, then CTRL=0x9. Expect `TMR_MODE` 01 then 10 on the write edges, `TMR_SRC`=01 throughout, and `rvalid` exactly 1 cycle after each `rd_en`.
